// File: rtl/resp_checker_if.sv
// Handshake bundle carrying (vector, response) pairs from the stimulus side into resp_checker.
interface resp_checker_if #(
   parameter int N_IN = 4
);
   logic            in_valid;
   logic [N_IN-1:0] in_vec;
   logic            in_resp;
   logic            in_ready;

   modport master (output in_valid, output in_vec, output in_resp, input in_ready);
   modport slave  (input in_valid, input in_vec, input in_resp, output in_ready);
endinterface

// File: rtl/resp_checker.sv
// Rebuilds the observed truth table of a combinational device from an ordered sweep of
// (vector, response) pairs and compares each response against EXP_TABLE.
//
// state   | meaning
// IDLE    | waiting for start, no transfers accepted
// COLLECT | sweep in progress, accepting vector idx
// DONE    | sweep complete, results and pass held until start or rst
module resp_checker #(
   parameter int                N_IN      = 4,
   parameter logic [2**N_IN-1:0] EXP_TABLE = 16'h4644
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   resp_checker_if.slave       in_if,
   output logic                busy_o,
   output logic                done_o,
   output logic                pass_o,
   output logic [2**N_IN-1:0]  obs_table_o,
   output logic [N_IN:0]       err_count_o,
   output logic                first_err_valid_o,
   output logic [N_IN-1:0]     first_err_vec_o,
   output logic                seq_err_o
);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t              state_q;
   logic [N_IN-1:0]     idx_q;
   logic [2**N_IN-1:0]  obs_table_q;
   logic [N_IN:0]       err_count_q;
   logic [N_IN:0]       err_count_d;
   logic                first_err_valid_q;
   logic [N_IN-1:0]     first_err_vec_q;
   logic                seq_err_q;
   logic                ready_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;

   logic                xfer_d;
   logic                in_order_d;
   logic                mismatch_d;
   logic                last_d;

   assign xfer_d      = in_if.in_valid && ready_q;
   assign in_order_d  = (in_if.in_vec == idx_q);
   assign mismatch_d  = (in_if.in_resp != EXP_TABLE[idx_q]);
   assign last_d      = &idx_q;
   assign err_count_d = err_count_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= IDLE;
         idx_q             <= '0;
         obs_table_q       <= '0;
         err_count_q       <= '0;
         first_err_valid_q <= 1'b0;
         first_err_vec_q   <= '0;
         seq_err_q         <= 1'b0;
         ready_q           <= 1'b0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         pass_q            <= 1'b0;
      end else if (start_i) begin
         // start wins from any state, including over a transfer on the same edge
         state_q           <= COLLECT;
         idx_q             <= '0;
         obs_table_q       <= '0;
         err_count_q       <= '0;
         first_err_valid_q <= 1'b0;
         first_err_vec_q   <= '0;
         seq_err_q         <= 1'b0;
         ready_q           <= 1'b1;
         busy_q            <= 1'b1;
         done_q            <= 1'b0;
         pass_q            <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (xfer_d) begin
                  if (in_order_d) begin
                     obs_table_q[idx_q] <= in_if.in_resp;
                     idx_q              <= idx_q + 1'b1;
                     if (mismatch_d) begin
                        err_count_q <= err_count_d;
                        if (!first_err_valid_q) begin
                           first_err_valid_q <= 1'b1;
                           first_err_vec_q   <= idx_q;
                        end
                     end
                     if (last_d) begin
                        state_q <= DONE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !seq_err_q && (err_count_q == '0) && !mismatch_d;
                     end
                  end else begin
                     seq_err_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_if.in_ready    = ready_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign pass_o            = pass_q;
   assign obs_table_o       = obs_table_q;
   assign err_count_o       = err_count_q;
   assign first_err_valid_o = first_err_valid_q;
   assign first_err_vec_o   = first_err_vec_q;
   assign seq_err_o         = seq_err_q;

endmodule

// File: tb/tb_resp_checker.sv
// Directed bench for resp_checker: clean, faulty, out-of-order, gapped and reset sweeps.
module tb_resp_checker;

   logic        clk;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] obs_table;
   logic [4:0]  err_count;
   logic        first_err_valid;
   logic [3:0]  first_err_vec;
   logic        seq_err;

   int checks   = 0;
   int failures = 0;

   logic [15:0] tab;

   resp_checker_if #(.N_IN(4)) bus ();

   resp_checker #(.N_IN(4), .EXP_TABLE(16'h4644)) dut (
      .clk               (clk),
      .rst               (rst),
      .start_i           (start),
      .in_if             (bus),
      .busy_o            (busy),
      .done_o            (done),
      .pass_o            (pass),
      .obs_table_o       (obs_table),
      .err_count_o       (err_count),
      .first_err_valid_o (first_err_valid),
      .first_err_vec_o   (first_err_vec),
      .seq_err_o         (seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic xfer(input logic [3:0] vec, input logic resp);
      bus.in_valid = 1'b1;
      bus.in_vec   = vec;
      bus.in_resp  = resp;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic sweep(input logic [15:0] rtab, input int first, input int last, input int gap);
      for (int i = first; i <= last; i++) begin
         xfer(4'(i), rtab[i]);
         repeat (gap) tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_vec = '0;
      bus.in_resp = 1'b0;
      repeat (2) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_obs", 32'(obs_table), 32'h0);
      rst = 1'b0;
      tick();

      // clean gap-free sweep
      pulse_start();
      check("start_busy", 32'(busy), 32'd1);
      check("start_ready", 32'(bus.in_ready), 32'd1);
      tab = 16'h4644;
      sweep(tab, 0, 14, 0);
      check("pre_last_done", 32'(done), 32'd0);
      sweep(tab, 15, 15, 0);
      check("clean_done", 32'(done), 32'd1);
      check("clean_busy", 32'(busy), 32'd0);
      check("clean_ready", 32'(bus.in_ready), 32'd0);
      check("clean_obs", 32'(obs_table), 32'h4644);
      check("clean_err", 32'(err_count), 32'd0);
      check("clean_pass", 32'(pass), 32'd1);
      check("clean_fev", 32'(first_err_valid), 32'd0);
      tick();
      check("clean_hold_pass", 32'(pass), 32'd1);

      // single fault at vector 9
      pulse_start();
      tab = 16'h4444;
      sweep(tab, 0, 15, 0);
      check("f1_obs", 32'(obs_table), 32'h4444);
      check("f1_err", 32'(err_count), 32'd1);
      check("f1_fev", 32'(first_err_valid), 32'd1);
      check("f1_fvec", 32'(first_err_vec), 32'd9);
      check("f1_pass", 32'(pass), 32'd0);
      check("f1_done", 32'(done), 32'd1);

      // faults at vectors 2 and 15 (last-vector mismatch must still kill pass)
      pulse_start();
      tab = 16'hC640;
      sweep(tab, 0, 15, 0);
      check("f2_obs", 32'(obs_table), 32'hC640);
      check("f2_err", 32'(err_count), 32'd2);
      check("f2_fvec", 32'(first_err_vec), 32'd2);
      check("f2_pass", 32'(pass), 32'd0);

      // out-of-order vector 5 after 3
      pulse_start();
      tab = 16'h4644;
      sweep(tab, 0, 3, 0);
      xfer(4'd5, 1'b1);
      check("ooo_seq", 32'(seq_err), 32'd1);
      check("ooo_obs_mid", 32'(obs_table), 32'h0004);
      sweep(tab, 4, 15, 0);
      check("ooo_done", 32'(done), 32'd1);
      check("ooo_pass", 32'(pass), 32'd0);
      check("ooo_obs", 32'(obs_table), 32'h4644);
      check("ooo_err", 32'(err_count), 32'd0);

      // gapped sweep
      pulse_start();
      sweep(tab, 0, 14, 3);
      check("gap_busy", 32'(busy), 32'd1);
      sweep(tab, 15, 15, 3);
      check("gap_done", 32'(done), 32'd1);
      check("gap_obs", 32'(obs_table), 32'h4644);
      check("gap_pass", 32'(pass), 32'd1);

      // restart from DONE
      pulse_start();
      check("rs_done", 32'(done), 32'd0);
      check("rs_busy", 32'(busy), 32'd1);
      check("rs_obs", 32'(obs_table), 32'h0);
      check("rs_pass", 32'(pass), 32'd0);

      // abort mid-sweep; start coincident with a wrong transfer drops that sample
      sweep(16'hFFFF, 0, 2, 0);
      check("ab_err_mid", 32'(err_count), 32'd2);
      bus.in_valid = 1'b1;
      bus.in_vec   = 4'd0;
      bus.in_resp  = 1'b1;
      pulse_start();
      bus.in_valid = 1'b0;
      check("ab_err_clr", 32'(err_count), 32'd0);
      check("ab_obs_clr", 32'(obs_table), 32'h0);
      check("ab_busy", 32'(busy), 32'd1);
      sweep(tab, 0, 15, 0);
      check("ab_done", 32'(done), 32'd1);
      check("ab_pass", 32'(pass), 32'd1);

      // reset mid-sweep
      pulse_start();
      sweep(tab, 0, 7, 0);
      check("mr_obs_pre", 32'(obs_table), 32'h0044);
      rst = 1'b1;
      #2;
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_ready", 32'(bus.in_ready), 32'd0);
      check("mr_obs", 32'(obs_table), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_vec   = 4'd0;
      bus.in_resp  = 1'b1;
      repeat (3) tick();
      check("mr_idle_busy", 32'(busy), 32'd0);
      check("mr_idle_ready", 32'(bus.in_ready), 32'd0);
      check("mr_idle_obs", 32'(obs_table), 32'h0);
      check("mr_idle_seq", 32'(seq_err), 32'd0);
      bus.in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/resp_checker.md
Name: resp_checker

Overview:
- Sequential response checker that sits on the output side of a combinational device under test.
- A stimulus source sweeps all 2^N_IN input vectors through the device. This block accepts each (vector, response) pair over a valid/ready handshake.
- It rebuilds the device's observed truth table, compares every response against an expected truth-table constant, and reports pass/fail plus the first failing vector.
- Default expectation is t = pq'r's + rs' with vector order {p,q,r,s}.

Parameters:
- N_IN, 4, number of device inputs; a full sweep is 2^N_IN vectors.
- EXP_TABLE, 16'h4644, expected truth table; bit i is the expected response for vector i. Width is 2^N_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that clears results and begins a sweep.
- in_valid  input  1  a (vector, response) pair is presented.
- in_vec  input  N_IN  input vector applied to the device ({p,q,r,s}, p = MSB).
- in_resp  input  1  device response for in_vec.
- in_ready  output  1  block can accept a pair.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; results valid.
- pass  output  1  sweep completed with no mismatches and no sequence errors.
- obs_table  output  2^N_IN  observed truth table; bit i is the response captured for vector i.
- err_count  output  N_IN+1  number of response mismatches.
- first_err_valid  output  1  at least one mismatch has been recorded.
- first_err_vec  output  N_IN  vector of the first mismatch.
- seq_err  output  1  an out-of-order vector was presented.

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE and every output and register clears to 0, including idx, obs_table, err_count, first_err_vec, first_err_valid, seq_err, done and pass.
- State machine has three states: IDLE, COLLECT, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start moves to COLLECT and clears all results and idx.
- COLLECT:
  - in_ready=1, busy=1.
  - A transfer occurs when in_valid and in_ready are both 1 on a rising edge.
  - If in_vec == idx: obs_table[idx] <= in_resp.
  - If in_resp != EXP_TABLE[idx]: err_count increments. On the first such mismatch, first_err_vec <= idx and first_err_valid <= 1.
  - After a matching-order transfer, idx increments.
  - If idx == 2^N_IN-1 at that transfer, the next state is DONE.
  - If in_vec != idx: seq_err <= 1 (sticky). The sample is discarded, idx is unchanged and there is no error count.
  - A cycle with in_valid=0 is idle and has no effect. Gaps of any length are allowed.
- DONE:
  - done=1, busy=0, in_ready=0.
  - pass = (err_count==0) and !seq_err, held stable.
  - Results hold until start or rst. start returns to COLLECT with results cleared.
- start while in COLLECT aborts and restarts the sweep: clear everything, idx=0, remain in COLLECT.
- start has priority over a simultaneous transfer; that sample is dropped.
- Latency:
  - Each result register updates on the edge that accepts the transfer.
  - done asserts on the edge that accepts the last vector.
  - A gap-free sweep accepts 2^N_IN transfers on 2^N_IN consecutive edges after entering COLLECT.
- Width rules:
  - idx is N_IN bits.
  - err_count is N_IN+1 bits and cannot overflow, since at most 2^N_IN mismatches are possible.
- Reset mid-sweep abandons all progress; the block is in IDLE on the first edge after rst deasserts.

Test Plan:
- Gap-free correct sweep: pulse start, then drive vectors 0..15 with the correct t on consecutive cycles → done=1 after the 16th transfer, obs_table=16'h4644, err_count=0, pass=1, first_err_valid=0.
- Single fault: as above but return in_resp=0 for vector 9 → obs_table=16'h4444, err_count=1, first_err_valid=1, first_err_vec=9, pass=0.
- Multiple faults: invert responses for vectors 2 and 15 → err_count=2, first_err_vec=2, obs_table=16'hC640.
- Out-of-order: after vector 3, present vector 5, then continue 4..15 → seq_err=1, vector 5 is discarded and later accepted in order, done=1, pass=0, obs_table=16'h4644.
- Handshake gaps and restart: drive in_valid=0 for 3 cycles between each vector → the same results as the gap-free run. While done=1, pulse start → done=0, busy=1 and results cleared on the next edge.
- Reset mid-sweep: assert rst after vector 7 → all outputs 0 immediately, without waiting for a clock edge. Hold in_valid=1 after rst deasserts → no transfer occurs until start.
